// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter that scans the granted requester's W-bit word MSB-first for overlapping "1001".
// Grant-to-done is W+1 cycles; req is ignored while busy, so a requester holds req until granted.
module seq_scan_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       data,
   output logic [N-1:0]         gnt,
   output logic                 busy,
   output logic                 det_bit,
   output logic                 done,
   output logic [$clog2(N)-1:0] done_id,
   output logic [$clog2(W):0]   match_cnt
);

   localparam int IW = $clog2(N);
   localparam int BW = $clog2(W);
   localparam int CW = BW + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] REPORT = 2'd2;

   localparam logic [2:0] DS0 = 3'd0;
   localparam logic [2:0] DS1 = 3'd1;
   localparam logic [2:0] DS2 = 3'd2;
   localparam logic [2:0] DS3 = 3'd3;
   localparam logic [2:0] DS4 = 3'd4;

   logic [1:0]    state;
   logic [2:0]    dstate;
   logic [2:0]    dnext;
   logic [W-1:0]  word;
   logic [BW-1:0] bidx;
   logic [CW-1:0] acc;
   logic [CW-1:0] acc_next;
   logic [IW-1:0] ptr;
   logic [IW-1:0] sel;
   logic          sel_vld;
   logic          din;

   // Two passes: requesters above the last grant first, then wrap to the low end.
   always_comb begin
      sel_vld = 1'b0;
      sel     = '0;
      for (int i = 0; i < N; i++) begin
         if (!sel_vld && req[i] && (i > int'(ptr))) begin
            sel_vld = 1'b1;
            sel     = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!sel_vld && req[i] && (i <= int'(ptr))) begin
            sel_vld = 1'b1;
            sel     = IW'(i);
         end
      end
   end

   assign din = word[W-1];

   always_comb begin
      dnext = DS0;
      case (dstate)
         DS0:     dnext = din ? DS1 : DS0;
         DS1:     dnext = din ? DS1 : DS2;
         DS2:     dnext = din ? DS1 : DS3;
         DS3:     dnext = din ? DS4 : DS0;
         DS4:     dnext = din ? DS1 : DS2;
         default: dnext = DS0;
      endcase
   end

   assign acc_next = acc + {{(CW-1){1'b0}}, (dnext == DS4)};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dstate    <= DS0;
         word      <= '0;
         bidx      <= '0;
         acc       <= '0;
         ptr       <= IW'(N-1);
         done_id   <= '0;
         match_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  word   <= data[sel*W +: W];
                  ptr    <= sel;
                  dstate <= DS0;
                  bidx   <= '0;
                  acc    <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               dstate <= dnext;
               acc    <= acc_next;
               word   <= {word[W-2:0], 1'b0};
               if (bidx == BW'(W-1)) begin
                  // The last bit may complete a match, so publish the post-update count.
                  match_cnt <= acc_next;
                  done_id   <= ptr;
                  state     <= REPORT;
               end else begin
                  bidx <= bidx + 1'b1;
               end
            end
            REPORT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Grant and busy are combinational off req in IDLE, so they are gated by reset directly.
   assign gnt     = (rst && (state == IDLE) && sel_vld) ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
   assign busy    = rst && ((state != IDLE) || sel_vld);
   assign det_bit = (state == SHIFT) && (dstate == DS4);
   assign done    = (state == REPORT);

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter (N=4, W=8): grant timing, detector output, counts and round-robin order.
module tb_seq_scan_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int T = 10;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           det_bit;
   logic           done;
   logic [1:0]     done_id;
   logic [3:0]     match_cnt;

   int checks;
   int errors;

   seq_scan_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .busy      (busy),
      .det_bit   (det_bit),
      .done      (done),
      .done_id   (done_id),
      .match_cnt (match_cnt)
   );

   initial clk = 1'b0;
   always #(T/2) clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full word: grant cycle, W SHIFT cycles, REPORT. Ends at the REPORT negedge.
   // emask bit k is the expected det_bit in SHIFT cycle k.
   task automatic do_word(input string tag,
                          input logic [N-1:0] r, input logic [N*W-1:0] d,
                          input logic [N-1:0] r2, input logic [N*W-1:0] d2,
                          input logic [N-1:0] eg, input int eid, input int ecnt,
                          input logic [W-1:0] emask, output int tg);
      logic [W-1:0] m;
      int spur;
      @(negedge clk);
      req  = r;
      data = d;
      #1;
      tg = int'($time);
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".busy_g"}, 32'(busy), 32'd1);
      @(negedge clk);
      req  = r2;
      data = d2;
      m    = '0;
      spur = 0;
      for (int k = 0; k < W; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         m[k] = det_bit;
         if (gnt !== '0 || done !== 1'b0 || busy !== 1'b1) spur++;
      end
      chk({tag, ".det"}, 32'(m), 32'(emask));
      chk({tag, ".shift_outs"}, 32'(spur), 32'd0);
      @(negedge clk);
      #1;
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".done_id"}, 32'(done_id), 32'(eid));
      chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(ecnt));
      chk({tag, ".rep_outs"}, {29'd0, gnt == '0, det_bit, busy}, {29'd0, 1'b1, 1'b0, 1'b1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, t3;
      int dn;
      checks = 0;
      errors = 0;

      // Reset state, with requests asserted to show grant is suppressed
      rst  = 1'b0;
      req  = '1;
      data = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.gnt", 32'(gnt), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.det", 32'(det_bit), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.done_id", 32'(done_id), 32'd0);
      chk("rst.match_cnt", 32'(match_cnt), 32'd0);
      req = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("idle.gnt", 32'(gnt), 32'd0);
      chk("idle.busy", 32'(busy), 32'd0);

      // Single-requester words with hand-counted "1001" occurrences
      do_word("w92", 4'b0001, 32'h0000_0092, 4'b0000, 32'h0000_0092, 4'b0001, 0, 2, 8'h90, t0);
      do_word("w90", 4'b0001, 32'h0000_0090, 4'b0000, 32'h0000_0090, 4'b0001, 0, 1, 8'h10, t0);
      do_word("w00", 4'b0001, 32'h0000_0000, 4'b0000, 32'h0000_0000, 4'b0001, 0, 0, 8'h00, t0);
      do_word("w99", 4'b0001, 32'h0000_0099, 4'b0000, 32'h0000_0099, 4'b0001, 0, 2, 8'h10, t0);
      // Data changed to FF right after the grant must not disturb the scan
      do_word("wff", 4'b0001, 32'h0000_0092, 4'b0000, 32'h0000_00FF, 4'b0001, 0, 2, 8'h90, t0);

      // Reset in SHIFT cycle 3 aborts the word
      @(negedge clk);
      req  = 4'b0001;
      data = 32'h0000_0092;
      #1;
      chk("abort.gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      req = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("abort.busy_pre", 32'(busy), 32'd1);
      rst = 1'b0;
      req = '1;
      #1;
      chk("abort.gnt", 32'(gnt), 32'd0);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.det", 32'(det_bit), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.done_id", 32'(done_id), 32'd0);
      chk("abort.match_cnt", 32'(match_cnt), 32'd0);
      dn = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         if (done !== 1'b0) dn++;
      end
      chk("abort.no_done", 32'(dn), 32'd0);
      req = '0;
      rst = 1'b1;
      do_word("post_rst", 4'b1000, 32'h9900_0000, 4'b0000, 32'h9900_0000, 4'b1000, 3, 2, 8'h10, t0);

      // Round-robin over all four, each dropping req once granted
      do_word("rr0", 4'b1111, 32'h9900_9092, 4'b1110, 32'h9900_9092, 4'b0001, 0, 2, 8'h90, t0);
      do_word("rr1", 4'b1110, 32'h9900_9092, 4'b1100, 32'h9900_9092, 4'b0010, 1, 1, 8'h10, t0);
      do_word("rr2", 4'b1100, 32'h9900_9092, 4'b1000, 32'h9900_9092, 4'b0100, 2, 0, 8'h00, t0);
      do_word("rr3", 4'b1000, 32'h9900_9092, 4'b0000, 32'h9900_9092, 4'b1000, 3, 2, 8'h10, t0);
      do_word("rr5a", 4'b0101, 32'h9900_9092, 4'b0100, 32'h9900_9092, 4'b0001, 0, 2, 8'h90, t0);
      do_word("rr5b", 4'b0100, 32'h9900_9092, 4'b0000, 32'h9900_9092, 4'b0100, 2, 0, 8'h00, t0);

      // Two requesters held continuously alternate at minimum spacing
      do_word("alt1a", 4'b0110, 32'h0090_0000, 4'b0110, 32'h0090_0000, 4'b0010, 1, 0, 8'h00, t0);
      do_word("alt2a", 4'b0110, 32'h0090_0000, 4'b0110, 32'h0090_0000, 4'b0100, 2, 1, 8'h10, t1);
      do_word("alt1b", 4'b0110, 32'h0090_0000, 4'b0110, 32'h0090_0000, 4'b0010, 1, 0, 8'h00, t2);
      do_word("alt2b", 4'b0110, 32'h0090_0000, 4'b0000, 32'h0090_0000, 4'b0100, 2, 1, 8'h10, t3);
      chk("alt.space1", 32'(t1 - t0), 32'((W + 2) * T));
      chk("alt.space2", 32'(t2 - t1), 32'((W + 2) * T));
      chk("alt.space3", 32'(t3 - t2), 32'((W + 2) * T));

      // Completion results hold in IDLE with no requests
      repeat (3) @(negedge clk);
      #1;
      chk("hold.gnt", 32'(gnt), 32'd0);
      chk("hold.busy", 32'(busy), 32'd0);
      chk("hold.done", 32'(done), 32'd0);
      chk("hold.done_id", 32'(done_id), 32'd2);
      chk("hold.match_cnt", 32'(match_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
